// File: rtl/eight_data_decompress_unit_if.sv
// Block-level bundle between compressed storage and the eight-word decompressor.
// The master drives compressed blocks and the slave returns decoded words and counters.
interface eight_data_decompress_unit_if;
    logic         wrtEn;
    logic [255:0] dataIn;
    logic [15:0]  tagIn;
    logic [7:0]   lenIn;
    logic [255:0] dataOut;
    logic         validOut;
    logic         errOut;
    logic [15:0]  blkCount;
    logic [7:0]   errCount;

    modport master (
        output wrtEn, dataIn, tagIn, lenIn,
        input  dataOut, validOut, errOut, blkCount, errCount
    );

    modport slave (
        input  wrtEn, dataIn, tagIn, lenIn,
        output dataOut, validOut, errOut, blkCount, errCount
    );
endinterface

// File: rtl/eight_data_decompress_unit.sv
// Three-stage decompressor: tag sizing/offsets, per-word byte extraction, output register.
// Accepts one compressed block per clock and emits the eight rebuilt words two edges later.
module eight_data_decompress_unit (
    input logic clk,
    input logic reset,
    eight_data_decompress_unit_if.slave bus
);
    localparam int WORDS   = 8;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = WORDS * WORD_W;

    logic [WORDS-1:0][5:0]        offset_in;
    logic [5:0]                   total_in;
    logic                         err_in;

    logic                         s1_valid;
    logic [BLOCK_W-1:0]           s1_data;
    logic [15:0]                  s1_tag;
    logic [WORDS-1:0][5:0]        s1_offset;
    logic                         s1_err;

    logic [WORDS-1:0][WORD_W-1:0] words_next;
    logic                         s2_valid;
    logic [WORDS-1:0][WORD_W-1:0] s2_words;
    logic                         s2_err;

    // Pull one word out of the packed payload; bytes beyond its own size are masked off.
    function automatic logic [WORD_W-1:0] extract(
        input logic [BLOCK_W-1:0] data,
        input logic [5:0]         offset,
        input logic [1:0]         tag
    );
        logic [WORD_W-1:0] window;
        window = WORD_W'(data >> {offset, 3'b000});
        case (tag)
            2'b00:   return '0;
            2'b01:   return {24'd0, window[7:0]};
            2'b10:   return {16'd0, window[15:0]};
            default: return window;
        endcase
    endfunction

    always_comb begin
        logic [5:0] size;
        total_in  = '0;
        offset_in = '0;
        for (int i = 0; i < WORDS; i++) begin
            case (bus.tagIn[2*i +: 2])
                2'b00:   size = 6'd0;
                2'b01:   size = 6'd1;
                2'b10:   size = 6'd2;
                default: size = 6'd4;
            endcase
            offset_in[i] = total_in;
            total_in     = total_in + size;
        end
        err_in = (bus.lenIn != {2'b00, total_in});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_tag    <= '0;
            s1_offset <= '0;
            s1_err    <= 1'b0;
        end else begin
            s1_valid <= bus.wrtEn;
            if (bus.wrtEn) begin
                s1_data   <= bus.dataIn;
                s1_tag    <= bus.tagIn;
                s1_offset <= offset_in;
                s1_err    <= err_in;
            end
        end
    end

    always_comb begin
        words_next = '0;
        for (int i = 0; i < WORDS; i++) begin
            words_next[i] = extract(s1_data, s1_offset[i], s1_tag[2*i +: 2]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_words <= '0;
            s2_err   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_words <= words_next;
                s2_err   <= s1_err;
            end
        end
    end

    // Output and counters move only on real blocks, so bubbles leave dataOut untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dataOut  <= '0;
            bus.validOut <= 1'b0;
            bus.errOut   <= 1'b0;
            bus.blkCount <= '0;
            bus.errCount <= '0;
        end else begin
            bus.validOut <= s2_valid;
            if (s2_valid) begin
                bus.dataOut  <= s2_words;
                bus.errOut   <= s2_err;
                bus.blkCount <= bus.blkCount + 16'd1;
                if (s2_err && (bus.errCount != 8'hFF)) begin
                    bus.errCount <= bus.errCount + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_eight_data_decompress_unit.sv
// Self-checking bench for eight_data_decompress_unit: directed blocks plus random streams
// compared against a byte-walking reference model with a two-edge delay queue.
module tb_eight_data_decompress_unit;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    eight_data_decompress_unit_if bus ();

    eight_data_decompress_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [255:0] data;
        logic         err;
    } exp_t;

    exp_t         pipe[$];
    logic         exp_valid;
    logic [255:0] exp_data;
    logic         exp_err;
    logic [15:0]  exp_blk;
    logic [7:0]   exp_errc;
    logic [255:0] mixed_blk;
    logic [255:0] mixed_words;
    int           checks = 0;
    int           errors = 0;

    // Walk the payload byte by byte in word order, as the compressor packed it.
    function automatic void ref_decode(input logic [255:0] d, input logic [15:0] t,
                                       output logic [255:0] w, output int tot);
        int pos;
        pos = 0;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            int n;
            case (t[2*i +: 2])
                2'd0:    n = 0;
                2'd1:    n = 1;
                2'd2:    n = 2;
                default: n = 4;
            endcase
            for (int b = 0; b < n; b++) w[32*i + 8*b +: 8] = d[8*(pos + b) +: 8];
            pos += n;
        end
        tot = pos;
    endfunction

    task automatic cycle(input logic we, input logic [255:0] d, input logic [15:0] t,
                         input logic [7:0] l);
        exp_t e;
        exp_t o;
        int   tot;
        bus.wrtEn  = we;
        bus.dataIn = d;
        bus.tagIn  = t;
        bus.lenIn  = l;
        e.valid = we;
        ref_decode(d, t, e.data, tot);
        e.err = (int'(l) != tot);
        @(posedge clk);
        pipe.push_back(e);
        exp_valid = 1'b0;
        if (pipe.size() == 3) begin
            o = pipe.pop_front();
            exp_valid = o.valid;
            if (o.valid) begin
                exp_data = o.data;
                exp_err  = o.err;
                exp_blk++;
                if (o.err && exp_errc != 8'hFF) exp_errc++;
            end
        end
        #1;
    endtask

    task automatic bubble();
        cycle(1'b0, '0, 16'h0, 8'h0);
    endtask

    task automatic rand_block(output logic [255:0] d, output logic [15:0] t, output logic [7:0] l);
        logic [255:0] w;
        int tot;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        t = 16'($urandom);
        ref_decode(d, t, w, tot);
        l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'(tot);
    endtask

    // Assert reset between edges with a live block on the bus; the model drops everything.
    task automatic begin_reset();
        reset      = 1'b0;
        bus.wrtEn  = 1'b1;
        bus.dataIn = {8{32'h12345678}};
        bus.tagIn  = 16'hFFFF;
        bus.lenIn  = 8'd32;
        pipe.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_err   = 1'b0;
        exp_blk   = '0;
        exp_errc  = '0;
        #2;
    endtask

    task automatic end_reset();
        @(posedge clk);
        #2;
        bus.wrtEn = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        begin_reset();
        checks += 5;
        if (bus.dataOut !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.dataOut); end
        if (bus.validOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.validOut); end
        if (bus.errOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.errOut); end
        if (bus.blkCount !== 16'h0) begin errors++; $display("[TB] FAIL reset_blk: got %h expected 0", bus.blkCount); end
        if (bus.errCount !== 8'h0) begin errors++; $display("[TB] FAIL reset_errc: got %h expected 0", bus.errCount); end
        end_reset();
        for (int k = 0; k < 2; k++) begin
            bubble();
            checks++;
            if (bus.validOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_ignored_wrt: got %b expected 0", bus.validOut); end
        end
    endtask

    task automatic test_all_raw();
        logic [255:0] d;
        d = {8{32'hFEDCBA98}};
        cycle(1'b1, d, 16'hFFFF, 8'd32);
        bubble();
        checks++;
        if (bus.validOut !== 1'b0) begin errors++; $display("[TB] FAIL raw_early_valid: got %b expected 0", bus.validOut); end
        bubble();
        checks += 4;
        if (bus.validOut !== 1'b1) begin errors++; $display("[TB] FAIL raw_valid: got %b expected 1", bus.validOut); end
        if (bus.dataOut !== d) begin errors++; $display("[TB] FAIL raw_data: got %h expected %h", bus.dataOut, d); end
        if (bus.errOut !== 1'b0) begin errors++; $display("[TB] FAIL raw_err: got %b expected 0", bus.errOut); end
        if (bus.blkCount !== 16'd1) begin errors++; $display("[TB] FAIL raw_blk: got %0d expected 1", bus.blkCount); end
    endtask

    task automatic test_all_zero();
        cycle(1'b1, {32{8'hA5}}, 16'h0000, 8'd0);
        bubble();
        bubble();
        checks += 4;
        if (bus.validOut !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid: got %b expected 1", bus.validOut); end
        if (bus.dataOut !== '0) begin errors++; $display("[TB] FAIL zero_data: got %h expected 0", bus.dataOut); end
        if (bus.errOut !== 1'b0) begin errors++; $display("[TB] FAIL zero_err: got %b expected 0", bus.errOut); end
        if (bus.blkCount !== 16'd2) begin errors++; $display("[TB] FAIL zero_blk: got %0d expected 2", bus.blkCount); end
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 8; i++) mixed_blk[32*i +: 32] = $urandom;
        mixed_blk[55:0] = 56'h1FEDCBA9_8765_21;
        mixed_words = {32'h0, 32'h0, 32'h0, 32'h0, 32'h1FEDCBA9, 32'h00008765, 32'h0, 32'h00000021};
        cycle(1'b1, mixed_blk, 16'h00E1, 8'd7);
        bubble();
        bubble();
        checks += 3;
        if (bus.dataOut !== mixed_words) begin errors++; $display("[TB] FAIL mixed_data: got %h expected %h", bus.dataOut, mixed_words); end
        if (bus.errOut !== 1'b0) begin errors++; $display("[TB] FAIL mixed_err: got %b expected 0", bus.errOut); end
        if (bus.blkCount !== 16'd3) begin errors++; $display("[TB] FAIL mixed_blk: got %0d expected 3", bus.blkCount); end
    endtask

    task automatic test_mismatch();
        cycle(1'b1, mixed_blk, 16'h00E1, 8'd8);
        cycle(1'b1, mixed_blk, 16'h00E1, 8'd40);
        bubble();
        checks += 3;
        if (bus.dataOut !== mixed_words) begin errors++; $display("[TB] FAIL mis8_data: got %h expected %h", bus.dataOut, mixed_words); end
        if (bus.errOut !== 1'b1) begin errors++; $display("[TB] FAIL mis8_err: got %b expected 1", bus.errOut); end
        if (bus.errCount !== 8'd1) begin errors++; $display("[TB] FAIL mis8_errc: got %0d expected 1", bus.errCount); end
        bubble();
        checks += 4;
        if (bus.dataOut !== mixed_words) begin errors++; $display("[TB] FAIL mis40_data: got %h expected %h", bus.dataOut, mixed_words); end
        if (bus.errOut !== 1'b1) begin errors++; $display("[TB] FAIL mis40_err: got %b expected 1", bus.errOut); end
        if (bus.errCount !== 8'd2) begin errors++; $display("[TB] FAIL mis40_errc: got %0d expected 2", bus.errCount); end
        if (bus.blkCount !== 16'd5) begin errors++; $display("[TB] FAIL mis_blk: got %0d expected 5", bus.blkCount); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] d;
        logic [15:0]  t;
        logic [7:0]   l;
        int           gaps;
        begin_reset();
        end_reset();
        gaps = 0;
        for (int k = 0; k < 13; k++) begin
            if (k == 4 || k >= 11) begin
                bubble();
            end else begin
                rand_block(d, t, l);
                cycle(1'b1, d, t, l);
            end
            if (k >= 2 && bus.validOut === 1'b0) gaps++;
            checks += 3;
            if (bus.validOut !== exp_valid) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", k, bus.validOut, exp_valid); end
            if (exp_valid && (bus.dataOut !== exp_data || bus.errOut !== exp_err)) begin
                errors++; $display("[TB] FAIL stream_data[%0d]: got %h/%b expected %h/%b", k, bus.dataOut, bus.errOut, exp_data, exp_err);
            end
            if (bus.blkCount !== exp_blk || bus.errCount !== exp_errc) begin
                errors++; $display("[TB] FAIL stream_cnt[%0d]: got %0d/%0d expected %0d/%0d", k, bus.blkCount, bus.errCount, exp_blk, exp_errc);
            end
        end
        checks += 2;
        if (bus.blkCount !== 16'd10) begin errors++; $display("[TB] FAIL stream_blk: got %0d expected 10", bus.blkCount); end
        if (gaps != 1) begin errors++; $display("[TB] FAIL stream_gaps: got %0d expected 1", gaps); end
    endtask

    task automatic test_wrap();
        logic [255:0] d;
        logic [15:0]  t;
        logic [7:0]   l;
        for (int n = 0; n < 65525; n++) begin
            rand_block(d, t, l);
            cycle(1'b1, d, t, l);
            checks++;
            if (bus.validOut !== exp_valid || (exp_valid && bus.dataOut !== exp_data)) begin
                errors++; $display("[TB] FAIL preload_data[%0d]: got %b/%h expected %b/%h", n, bus.validOut, bus.dataOut, exp_valid, exp_data);
            end
        end
        bubble();
        bubble();
        checks += 2;
        if (bus.blkCount !== 16'hFFFF) begin errors++; $display("[TB] FAIL preload_blk: got %h expected ffff", bus.blkCount); end
        if (bus.errCount !== exp_errc) begin errors++; $display("[TB] FAIL preload_errc: got %h expected %h", bus.errCount, exp_errc); end
        cycle(1'b1, {8{32'hCAFEF00D}}, 16'hFFFF, 8'd40);
        bubble();
        bubble();
        checks += 3;
        if (bus.blkCount !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_blk: got %h expected 0000", bus.blkCount); end
        if (bus.errCount !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_errc: got %h expected ff", bus.errCount); end
        if (bus.errOut !== 1'b1) begin errors++; $display("[TB] FAIL wrap_err: got %b expected 1", bus.errOut); end
    endtask

    task automatic test_reset_midstream();
        logic [255:0] d;
        logic [15:0]  t;
        logic [7:0]   l;
        for (int k = 0; k < 3; k++) begin
            rand_block(d, t, l);
            cycle(1'b1, d, t, l);
        end
        begin_reset();
        checks += 5;
        if (bus.dataOut !== '0) begin errors++; $display("[TB] FAIL mid_data: got %h expected 0", bus.dataOut); end
        if (bus.validOut !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", bus.validOut); end
        if (bus.errOut !== 1'b0) begin errors++; $display("[TB] FAIL mid_err: got %b expected 0", bus.errOut); end
        if (bus.blkCount !== 16'h0) begin errors++; $display("[TB] FAIL mid_blk: got %h expected 0", bus.blkCount); end
        if (bus.errCount !== 8'h0) begin errors++; $display("[TB] FAIL mid_errc: got %h expected 0", bus.errCount); end
        end_reset();
        for (int k = 0; k < 3; k++) begin
            bubble();
            checks++;
            if (bus.validOut !== 1'b0) begin errors++; $display("[TB] FAIL mid_flush[%0d]: got %b expected 0", k, bus.validOut); end
        end
        rand_block(d, t, l);
        cycle(1'b1, d, t, l);
        bubble();
        bubble();
        checks += 3;
        if (bus.validOut !== 1'b1) begin errors++; $display("[TB] FAIL mid_next_valid: got %b expected 1", bus.validOut); end
        if (bus.dataOut !== exp_data) begin errors++; $display("[TB] FAIL mid_next_data: got %h expected %h", bus.dataOut, exp_data); end
        if (bus.blkCount !== 16'd1) begin errors++; $display("[TB] FAIL mid_next_blk: got %0d expected 1", bus.blkCount); end
    endtask

    initial begin
        bus.wrtEn  = 1'b0;
        bus.dataIn = '0;
        bus.tagIn  = '0;
        bus.lenIn  = '0;
        test_reset();
        test_all_raw();
        test_all_zero();
        test_mixed();
        test_mismatch();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
